throttle: RTL and testbench
===========================

// Module: throttle
// PURPOSE
//  Pushbutton-controlled clock throttle. Derives a slow square-wave enable clock
//  (slow_clk) from the 50 MHz board clock. Speed is a level index (freq_num) stepped
//  up/down by two pushbuttons; each level doubles the slow_clk frequency.
//  Sits between board I/O and the stepped logic that consumes slow_clk.
// PARAMETERS
//  BASE_DIV    25_000_000  half-period in CLK_50 cycles at level 0 (1 Hz); must satisfy BASE_DIV>>(NUM_LEVELS-1) >= 1
//  NUM_LEVELS  8           number of speed levels (0..NUM_LEVELS-1)
//  LVL_W       3           width of freq_num, = $clog2(NUM_LEVELS)
// PORTS
//  CLK_50      in   1      50 MHz system clock, all logic on rising edge
//  reset       in   1      synchronous, active-low reset
//  pb_freq_up  in   1      step-up pushbutton, active-high, asynchronous, externally debounced
//  pb_freq_dn  in   1      step-down pushbutton, active-high, asynchronous, externally debounced
//  slow_clk    out  1      divided square wave, 50% duty, registered
//  freq_num    out  LVL_W  current speed level, registered
// BEHAVIOUR
//  - Reset (reset==0 at a CLK_50 edge): slow_clk=0, freq_num=0, divider count=0,
//    all synchronizer/edge flops=0 (buttons treated as released).
//  - Button path: 2-FF synchronizer s1->s2, plus delay flop s3; step pulse = s2 & ~s3.
//    Button first sampled high at edge N -> freq_num updated at edge N+2.
//    One step per press regardless of hold length; no auto-repeat.
//  - Level update, evaluated each edge:
//      up pulse only: freq_num+1, saturate at NUM_LEVELS-1.
//      dn pulse only: freq_num-1, saturate at 0.
//      both same cycle: no change. No wrap-around ever.
//  - Divider: half = BASE_DIV >> freq_num (unsigned; counter width $clog2(BASE_DIV)).
//    if cnt == half-1: slow_clk toggles, cnt<=0; else cnt<=cnt+1.
//    slow_clk period = 2*half CLK_50 cycles; first toggle `half` edges after reset release.
//  - On any actual level change: cnt<=0 in the same edge, slow_clk holds its value;
//    next toggle exactly new `half` cycles later (no runt pulse).
//    Saturated presses do not clear cnt.
//  - Reset mid-operation overrides everything, including a pending step.
// STRUCTURE
//  - Package throttle_pkg: NUM_LEVELS, LVL_W, BASE_DIV defaults,
//    function half_period(level) returning BASE_DIV>>level.
//  - Sub-module btn_edge (sync + rising-edge pulse), instantiated twice.
//  - Top holds level register and divider.
// TESTING  (override BASE_DIV=256, NUM_LEVELS=8; 20 ns clock)
//  - Reset: hold reset=0 for 2 cycles -> slow_clk=0, freq_num=0;
//    after release slow_clk toggles every 256 cycles.
//  - Single up press, 5-cycle pulse -> freq_num 0->1 at edge N+2;
//    slow_clk half-period 128 from that edge; held button yields one step only.
//  - Press sequence up,up,dn,dn,up,up,dn,up,up,up (10 us apart)
//    -> freq_num 1,2,1,0,1,2,1,2,3,4; final half-period 16 cycles.
//  - Saturation: 9 ups from 0 -> 7 (half=2); then 9 dns -> 0 (half=256);
//    saturated presses leave cnt running.
//  - up and dn asserted on the same edge -> freq_num unchanged, cnt not cleared.
//  - At level 3, reset=0 for 1 cycle -> freq_num=0, slow_clk=0, divider restarts at 256.

Source files
------------

// File: rtl/throttle_pkg.sv
// Purpose: shared defaults and the half-period helper for the pushbutton clock throttle.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package throttle_pkg;

  localparam int unsigned DEF_BASE_DIV   = 25_000_000;  // level-0 half-period (1 Hz from 50 MHz)
  localparam int unsigned DEF_NUM_LEVELS = 8;
  localparam int unsigned DEF_LVL_W      = 3;

  // Half-period in core cycles for a given speed level; each level halves it.
  function automatic logic [31:0] half_period(input logic [31:0] level,
                                              input logic [31:0] base = DEF_BASE_DIV);
    return base >> level;
  endfunction

endpackage

// File: rtl/throttle_btn_edge.sv
// Purpose: synchronise an asynchronous, debounced button and emit a one-cycle rising-edge pulse.
// Latency: button sampled high at edge N -> o_pulse high between edges N+1 and N+2.
// Backpressure: none; one pulse per press however long the button is held.
// Ports: i_clk, i_rst_n (sync, active-low), i_btn (async level), o_pulse (1-cycle strobe).
module btn_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/throttle.sv
// Purpose: pushbutton-stepped divider producing a 50% duty slow_clk; each level doubles its rate.
// Latency: button high at edge N -> freq_num updated at edge N+2; slow_clk registered.
// Backpressure: none; simultaneous up/down presses cancel, out-of-range steps saturate.
// Ports: CLK_50, reset (sync, active-low), pb_freq_up/pb_freq_dn (async buttons),
//        slow_clk (divided square wave), freq_num (current speed level).
import throttle_pkg::*;

module throttle #(
  parameter int unsigned BASE_DIV   = DEF_BASE_DIV,
  parameter int unsigned NUM_LEVELS = DEF_NUM_LEVELS,
  parameter int unsigned LVL_W      = DEF_LVL_W
) (
  input  logic             CLK_50,
  input  logic             reset,
  input  logic             pb_freq_up,
  input  logic             pb_freq_dn,
  output logic             slow_clk,
  output logic [LVL_W-1:0] freq_num
);

  localparam int unsigned      CNT_W   = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(NUM_LEVELS - 1);

  logic [LVL_W-1:0] r_lvl;
  logic [CNT_W-1:0] r_cnt;
  logic             r_slow;

  logic             w_up;
  logic             w_dn;
  logic [LVL_W-1:0] w_lvl_nxt;
  logic             w_lvl_chg;
  logic [31:0]      w_half;
  logic [CNT_W-1:0] w_half_m1;

  btn_edge u_up (
    .i_clk   (CLK_50),
    .i_rst_n (reset),
    .i_btn   (pb_freq_up),
    .o_pulse (w_up)
  );

  btn_edge u_dn (
    .i_clk   (CLK_50),
    .i_rst_n (reset),
    .i_btn   (pb_freq_dn),
    .o_pulse (w_dn)
  );

  // Saturating step; both pulses together cancel out.
  always_comb begin
    w_lvl_nxt = r_lvl;
    if (w_up && !w_dn && (r_lvl != MAX_LVL)) begin
      w_lvl_nxt = r_lvl + LVL_W'(1);
    end else if (w_dn && !w_up && (r_lvl != '0)) begin
      w_lvl_nxt = r_lvl - LVL_W'(1);
    end
  end

  // Only a real level change restarts the divider; saturated presses leave it running.
  assign w_lvl_chg = (w_lvl_nxt != r_lvl);

  // half-1 always fits CNT_W bits even when half itself (BASE_DIV) needs one more.
  assign w_half    = half_period(32'(r_lvl), 32'(BASE_DIV));
  assign w_half_m1 = CNT_W'(w_half - 32'd1);

  always_ff @(posedge CLK_50) begin
    if (!reset) begin
      r_lvl  <= '0;
      r_cnt  <= '0;
      r_slow <= 1'b0;
    end else begin
      r_lvl <= w_lvl_nxt;
      if (w_lvl_chg) begin
        // slow_clk holds so the new rate starts with a full half-period, no runt.
        r_cnt <= '0;
      end else if (r_cnt == w_half_m1) begin
        r_cnt  <= '0;
        r_slow <= ~r_slow;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign slow_clk = r_slow;
  assign freq_num = r_lvl;

endmodule

// File: tb/tb_throttle.sv
module tb_throttle;

  localparam int BASE = 256;
  localparam int MAXL = 7;

  logic       CLK_50     = 1'b0;
  logic       reset      = 1'b0;
  logic       pb_freq_up = 1'b0;
  logic       pb_freq_dn = 1'b0;
  logic       slow_clk;
  logic [2:0] freq_num;

  int checks = 0;
  int errors = 0;
  int lvl_q[$];
  int half_q[$];
  int model_lvl = 0;

  always #10 CLK_50 = ~CLK_50;

  throttle #(.BASE_DIV(256), .NUM_LEVELS(8), .LVL_W(3)) dut (
    .CLK_50     (CLK_50),
    .reset      (reset),
    .pb_freq_up (pb_freq_up),
    .pb_freq_dn (pb_freq_dn),
    .slow_clk   (slow_clk),
    .freq_num   (freq_num)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  // Negedges until slow_clk changes; -1 if it never does within the budget.
  task automatic wait_toggle(output int n);
    logic s;
    s = slow_clk;
    n = 0;
    do begin
      @(negedge CLK_50);
      n++;
    end while (slow_clk === s && n < 2000);
    if (slow_clk === s) n = -1;
  endtask

  task automatic sync_toggle();
    int n;
    wait_toggle(n);
    if (n < 0) check("sync_timeout", 32'(n), 32'd1);
  endtask

  task automatic pop_lvl(input string tag);
    int e;
    if (lvl_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = lvl_q.pop_front();
      check(tag, 32'(freq_num), 32'(e));
    end
  endtask

  // Measures cycles to the next toggle, adding cycles already elapsed (off).
  task automatic measure_half(input string tag, input int off);
    int n;
    int e;
    wait_toggle(n);
    if (half_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = half_q.pop_front();
      check(tag, 32'((n < 0) ? n : n + off), 32'(e));
    end
  endtask

  // Press for 3 cycles; freq_num must stay put at N+1 and reach the model value at N+2.
  // meas_off >= 0 also measures the next half-period with that many cycles pre-elapsed.
  task automatic press(input bit up, input bit dn, input string tag, input int meas_off);
    int exp;
    exp = model_lvl;
    if (up && !dn) exp = (model_lvl == MAXL) ? MAXL : model_lvl + 1;
    if (dn && !up) exp = (model_lvl == 0) ? 0 : model_lvl - 1;
    lvl_q.push_back(exp);
    if (meas_off >= 0) half_q.push_back(BASE >> exp);
    pb_freq_up = up;
    pb_freq_dn = dn;
    tick(2);
    check({tag, "_early"}, 32'(freq_num), 32'(model_lvl));
    tick(1);
    pop_lvl(tag);
    pb_freq_up = 1'b0;
    pb_freq_dn = 1'b0;
    model_lvl = exp;
    if (meas_off >= 0) measure_half({tag, "_half"}, meas_off);
  endtask

  initial begin
    bit seq_up [10] = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1};

    // Reset held two cycles.
    reset = 1'b0;
    tick(2);
    check("rst_slow_clk", 32'(slow_clk), 32'd0);
    check("rst_freq_num", 32'(freq_num), 32'd0);
    half_q.push_back(256);
    reset = 1'b1;
    measure_half("first_toggle", 0);
    half_q.push_back(256);
    measure_half("lvl0_half", 0);
    tick(7);

    // Single up press held 5 cycles.
    lvl_q.push_back(1);
    half_q.push_back(128);
    pb_freq_up = 1'b1;
    tick(2);
    check("up1_early", 32'(freq_num), 32'd0);
    tick(1);
    pop_lvl("up1_step");
    tick(2);
    pb_freq_up = 1'b0;
    measure_half("up1_first_half", 2);
    model_lvl = 1;
    tick(30);
    check("up1_held_one_step", 32'(freq_num), 32'd1);
    sync_toggle();
    half_q.push_back(128);
    measure_half("up1_steady_half", 0);

    // Back to 0, then the press sequence 10 us apart.
    press(1'b0, 1'b1, "back_to_0", -1);
    tick(500);
    for (int i = 0; i < 10; i++) begin
      press(seq_up[i], !seq_up[i], "seq", (i == 9) ? 0 : -1);
      if (i < 9) tick(500);
    end
    check("seq_final_lvl", 32'(freq_num), 32'd4);

    // Both buttons together: no change, divider keeps counting.
    sync_toggle();
    press(1'b1, 1'b1, "both", 3);

    // Reset at level 3 with a step pending.
    press(1'b0, 1'b1, "dn_to_3", -1);
    tick(100);
    pb_freq_up = 1'b1;
    tick(1);
    reset = 1'b0;
    pb_freq_up = 1'b0;
    tick(1);
    check("midrst_freq_num", 32'(freq_num), 32'd0);
    check("midrst_slow_clk", 32'(slow_clk), 32'd0);
    model_lvl = 0;
    half_q.push_back(256);
    reset = 1'b1;
    measure_half("midrst_first_toggle", 0);
    check("midrst_pending_dropped", 32'(freq_num), 32'd0);

    // Saturation upward.
    for (int i = 0; i < 9; i++) begin
      press(1'b1, 1'b0, "sat_up", -1);
      tick(4);
    end
    check("sat_up_lvl", 32'(freq_num), 32'd7);
    sync_toggle();
    half_q.push_back(2);
    measure_half("lvl7_half", 0);

    // Saturation downward.
    for (int i = 0; i < 9; i++) begin
      press(1'b0, 1'b1, "sat_dn", -1);
      tick(4);
    end
    check("sat_dn_lvl", 32'(freq_num), 32'd0);
    sync_toggle();
    half_q.push_back(256);
    measure_half("lvl0_again_half", 0);
    sync_toggle();
    press(1'b0, 1'b1, "sat_dn_keeps_cnt", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
